// File: rtl/mio_clk_gen.sv
// mio_clk_gen: glitch-free programmable clock divider.
// Produces a registered clock with period N and high time H (in clk cycles),
// reconfigurable through a valid/ready port. New settings only land on a
// launch edge (leaving IDLE or LOW->HIGH), so every period is whole.
module mio_clk_gen #(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DEF_DIV  = 2,
   parameter int unsigned DEF_HIGH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_high,
   output logic             cfg_err,
   output logic             clk_o,
   output logic             active,
   output logic             edge_rise,
   output logic             edge_fall
);

   localparam logic [DIV_W-1:0] DefDiv  = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] DefHigh = DIV_W'(DEF_HIGH);
   localparam logic [DIV_W-1:0] One     = DIV_W'(1);
   localparam logic [DIV_W-1:0] Two     = DIV_W'(2);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] high_q, high_d;
   logic [DIV_W-1:0] pdiv_q, pdiv_d;
   logic [DIV_W-1:0] phigh_q, phigh_d;
   logic             pend_q, pend_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             err_q, err_d;

   logic             cfg_xfer;
   logic             cfg_legal;
   logic             launch;
   logic [DIV_W-1:0] low_len;

   // Next-state: phase counting, launch/config apply, handshake bookkeeping.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      high_d   = high_q;
      pdiv_d   = pdiv_q;
      phigh_d  = phigh_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      launch   = 1'b0;

      cfg_xfer  = cfg_valid && !pend_q;
      cfg_legal = (cfg_div >= Two) && (cfg_high != '0) && (cfg_high < cfg_div);
      // Legality guarantees this never underflows.
      low_len   = div_q - high_q;

      unique case (state_q)
         StIdle: begin
            if (en) launch = 1'b1;
         end
         StHigh: begin
            if (cnt_q == high_q) begin
               state_d = StLow;
               cnt_d   = One;
            end else begin
               cnt_d = cnt_q + One;
            end
         end
         StLow: begin
            if (cnt_q == low_len) begin
               if (en) begin
                  launch = 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + One;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // A launch consumes only config that was pending before this edge.
      if (launch) begin
         state_d = StHigh;
         cnt_d   = One;
         if (pend_q) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            pend_d = 1'b0;
         end
      end

      // cfg_xfer implies pend_q was clear, so this never collides with a consume.
      if (cfg_xfer && cfg_legal) begin
         pend_d  = 1'b1;
         pdiv_d  = cfg_div;
         phigh_d = cfg_high;
      end

      err_d  = cfg_xfer && !cfg_legal;
      clk_d  = (state_d == StHigh);
      rise_d = (state_d == StHigh) && (state_q != StHigh);
      fall_d = (state_q == StHigh) && (state_d == StLow);
   end

   // State and registered outputs; reset forces the clock low at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         div_q   <= DefDiv;
         high_q  <= DefHigh;
         pdiv_q  <= DefDiv;
         phigh_q <= DefHigh;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         high_q  <= high_d;
         pdiv_q  <= pdiv_d;
         phigh_q <= phigh_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         err_q   <= err_d;
      end
   end

   assign cfg_ready = !pend_q;
   assign cfg_err   = err_q;
   assign clk_o     = clk_q;
   assign active    = (state_q != StIdle);
   assign edge_rise = rise_q;
   assign edge_fall = fall_q;

endmodule

// File: tb/tb_mio_clk_gen.sv
// Bench for mio_clk_gen: expected per-cycle output tuples are queued from a
// period/high-time waveform model, then popped and compared each cycle.
module tb_mio_clk_gen;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_div;
   logic [7:0] cfg_high;
   logic       cfg_err;
   logic       clk_o;
   logic       active;
   logic       edge_rise;
   logic       edge_fall;

   // Tuple: {clk_o, edge_rise, edge_fall, active, cfg_ready, cfg_err}
   logic [5:0] exp_q[$];
   logic [5:0] exp_v;
   logic [5:0] obs;
   int         chk_cnt;
   int         pass_cnt;

   mio_clk_gen #(
      .DIV_W   (8),
      .DEF_DIV (2),
      .DEF_HIGH(1)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .cfg_err  (cfg_err),
      .clk_o    (clk_o),
      .active   (active),
      .edge_rise(edge_rise),
      .edge_fall(edge_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_period(input int n, input int h);
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i < h), (i == 0), (i == h), 1'b1, 1'b1, 1'b0});
   endtask

   task automatic push_idle(input int k);
      for (int i = 0; i < k; i++) exp_q.push_back(6'b000010);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      obs = {clk_o, edge_rise, edge_fall, active, cfg_ready, cfg_err};
   endtask

   task automatic test_reset();
      reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
      tick();
      chk_cnt++;
      if (obs !== 6'b000010) $display("FAIL reset_state: got %b want %b", obs, 6'b000010);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_default();
      for (int p = 0; p < 4; p++) push_period(2, 1);
      push_idle(3);
      en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL default cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         if (i == 6) en = 1'b0;
      end
   endtask

   task automatic test_cfg_idle();
      cfg_valid = 1'b1; cfg_div = 8'd5; cfg_high = 8'd2;
      tick();
      cfg_valid = 1'b0;
      chk_cnt++;
      if (obs !== 6'b000000) $display("FAIL cfg_idle_pending: got %b want %b", obs, 6'b000000);
      else pass_cnt++;
      for (int p = 0; p < 3; p++) push_period(5, 2);
      push_idle(3);
      en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL cfg_idle cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         if (i == 10) en = 1'b0;
      end
   endtask

   task automatic test_reconfig();
      push_period(5, 2);
      for (int k = 1; k < 5; k++) exp_q[k][1] = 1'b0;
      push_period(8, 6);
      push_period(8, 6);
      push_idle(3);
      en = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL reconfig cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         cfg_valid = 1'b0;
         if (i == 0) begin
            cfg_valid = 1'b1; cfg_div = 8'd8; cfg_high = 8'd6;
         end
         if (i == 13) en = 1'b0;
      end
   endtask

   task automatic test_illegal();
      push_period(8, 6);
      push_period(8, 6);
      push_idle(3);
      exp_q[1][0] = 1'b1;
      exp_q[4][0] = 1'b1;
      exp_q[9][0] = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 19; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL illegal cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         cfg_valid = 1'b0;
         case (i)
            0: begin cfg_valid = 1'b1; cfg_div = 8'd1; cfg_high = 8'd1; end
            3: begin cfg_valid = 1'b1; cfg_div = 8'd4; cfg_high = 8'd0; end
            8: begin cfg_valid = 1'b1; cfg_div = 8'd4; cfg_high = 8'd4; end
            default: ;
         endcase
         if (i == 8) en = 1'b0;
      end
   endtask

   task automatic test_en_drop();
      cfg_valid = 1'b1; cfg_div = 8'd6; cfg_high = 8'd3;
      tick();
      cfg_valid = 1'b0;
      chk_cnt++;
      if (cfg_ready !== 1'b0) $display("FAIL en_drop_ready: got %b want 0", cfg_ready);
      else pass_cnt++;
      push_period(6, 3);
      push_idle(3);
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL en_drop cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         if (i == 0) en = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      cfg_valid = 1'b1; cfg_div = 8'd8; cfg_high = 8'd4;
      tick();
      cfg_valid = 1'b0;
      exp_q.push_back(6'b110110);
      exp_q.push_back(6'b100100);
      en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         cfg_valid = 1'b0;
         // Leaves a pending 3/1 that the reset must discard.
         if (i == 0) begin
            cfg_valid = 1'b1; cfg_div = 8'd3; cfg_high = 8'd1;
         end
      end
      cfg_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk_cnt++;
      if (clk_o !== 1'b0) $display("FAIL reset_mid_clk: got %b want 0", clk_o);
      else pass_cnt++;
      chk_cnt++;
      if ({active, cfg_ready} !== 2'b01)
         $display("FAIL reset_mid_state: got %b want 01", {active, cfg_ready});
      else pass_cnt++;
      #1 reset_n = 1'b1;
      push_period(2, 1);
      push_period(2, 1);
      push_idle(2);
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_v = exp_q.pop_front();
         chk_cnt++;
         if (obs !== exp_v) $display("FAIL reset_defaults cyc%0d: got %b want %b", i, obs, exp_v);
         else pass_cnt++;
         if (i == 2) en = 1'b0;
      end
   endtask

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      test_reset();
      test_default();
      test_cfg_idle();
      test_reconfig();
      test_illegal();
      test_en_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
